sd_cmd_engine: RTL and testbench
================================

# sd_cmd_engine

Parametrised SD-bus command-line engine for the SD/FAT32 path. It generates the SD clock from the system clock and serialises a 48-bit command frame with CRC7. It then optionally receives and checks a short (48-bit) or long (136-bit) response, with a response timeout and a post-transaction idle gap. It sits between the SD initialisation/read controller and the SD pads, and unlike a plain command transmitter it owns the SD clock and the response path.

## Interface
- CLK_DIV, 2, system clocks per SD-clock half period; legal range ≥1; SD clock = clk/(2·CLK_DIV).
- RESP_TIMEOUT, 64, SD clocks allowed between the command end bit and the response start bit (NCR).
- NCC_GAP, 8, SD clocks with the line released after each transaction before returning to IDLE.
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  system clock; all logic runs on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sd_clk_o  out  1  SD clock; free-running, starts low out of reset.
- sd_cmd_i  in  1  CMD pad input.
- sd_cmd_o  out  1  CMD pad output value.
- sd_cmd_oen  out  1  output enable, active low (0 = drive).
- i_en  in  1  start request; accepted in IDLE only.
- i_cmd  in  6  command index.
- i_arg  in  32  command argument.
- i_resp_type  in  2  response type: 0 = none, 1 = short R1/R6/R7 (CRC checked), 2 = long R2, 3 = short R3 (no CRC).
- o_busy  out  1  high from the accepting cycle until the DONE cycle inclusive.
- o_done  out  1  one-cycle completion pulse.
- o_timeout  out  1  valid with o_done; no start bit was seen within RESP_TIMEOUT.
- o_crc_err  out  1  valid with o_done; the received CRC7 mismatched.
- o_resp_idx  out  6  short response: index field; long response: 6'h3F field.
- o_resp  out  128  short: [31:0] = argument field, upper bits 0; long: [127:1] = CID/CSD including CRC, [0] = end bit.

## Operation
- Divider counter runs 0..CLK_DIV-1. At terminal count sd_clk_o toggles, producing a one-cycle `fall` or `rise` strobe.
- States: IDLE → TX → (resp_type 0) GAP; TX → WAIT → RX → GAP; WAIT → GAP on timeout; GAP → DONE → IDLE.
- IDLE: sd_cmd_oen=1, sd_cmd_o=1. When i_en=1, latch i_cmd, i_arg and i_resp_type, assert o_busy, clear the result flags, and enter TX. The first bit is presented on the next `fall`.
- TX: on each `fall`, drive one bit MSB-first: 0, 1, i_cmd[5:0], i_arg[31:0], CRC7[6:0], 1. The frame is 48 bits. CRC7 uses polynomial x^7+x^3+1, zero seed, computed over the first 40 bits and cleared at every start. sd_cmd_oen=0 during TX.
- After the end bit has been held for one full SD clock, release the line (oen=1, o=1).
- WAIT: count `rise` strobes. If sd_cmd_i=0 is seen on a `rise`, it is the start bit: enter RX. If RESP_TIMEOUT rises pass without a start bit, set o_timeout and go to GAP.
- RX: sample on `rise`. Total frame is 48 bits (short) or 136 bits (long), counting the start bit. Shift data into o_resp / o_resp_idx per the field map.
  - Short CRC: over received bits 47..8.
  - Long CRC: over bits 127..8 of the payload (the 8 header bits are excluded).
  - Type 3: no CRC check.
- GAP: NCC_GAP `rise` strobes with the line released.
- DONE: o_done=1 for one cycle, o_busy stays 1, then IDLE.
- o_resp and the flags hold their values until the next accepted start.
- i_en outside IDLE is ignored. i_en held high re-triggers only after DONE.
- Reset mid-operation: immediate abort to IDLE with every output at its reset value; the CRC is cleared.

## Timing
- Reset values: sd_clk_o=0, sd_cmd_o=1, sd_cmd_oen=1, o_busy=0, o_done=0, o_timeout=0, o_crc_err=0, o_resp_idx=0, o_resp=0.
- o_busy rises the cycle after i_en is sampled in IDLE.
- Each command bit is stable from a `fall` until the next `fall`: 2·CLK_DIV clk cycles.
- Command with no response: (48+NCC_GAP) SD clocks plus at most one SD clock of alignment, then a 1-cycle DONE.
- The timeout counter starts at the first `rise` after the end bit is released.
- A start bit seen on the same `rise` on which the count reaches RESP_TIMEOUT is accepted; the start bit takes priority over the timeout.

## Configuration
- SD_CMD_RESP_CRC_CHECK_EN defined: the receive CRC7 engine is built and o_crc_err reports a mismatch.
- Not defined: no receive CRC logic is built, o_crc_err is tied 0, and response capture and timing are unchanged. The transmit CRC is always built.

## Test plan
- CMD0, arg 0, type 0, CLK_DIV=2 → line carries 0x40_00000000_95 MSB-first; o_done after 56 SD clocks; o_timeout=0.
- CMD8, arg 0x000001AA, type 1; card model replies 0x08_000001AA_13 after 5 SD clocks → TX frame ends in byte 0x87; o_resp_idx=8, o_resp[31:0]=0x000001AA, o_crc_err=0.
- Same as the previous case, but the card's last byte is corrupted to 0x15 → o_crc_err=1 with the macro defined, 0 without it.
- CMD17, arg 0, type 1; no reply → o_timeout=1 after exactly 64 rises; o_done pulses once; o_resp is unchanged.
- CMD2, type 2; a 136-bit CID is returned → o_resp[127:1] matches the CID, o_resp[0]=1, o_crc_err=0.
- rst_n pulsed low at bit 20 of TX, then CMD55 issued → outputs are at reset values during reset; the next frame is 0x77_00000000_65, proving the CRC was cleared.

Source files
------------

// File: rtl/sd_cmd_engine_if.sv
// rtl/sd_cmd_engine_if.sv - request/result bus between the SD init/read controller and sd_cmd_engine
interface sd_cmd_engine_if;
  logic         i_en;
  logic [5:0]   i_cmd;
  logic [31:0]  i_arg;
  logic [1:0]   i_resp_type;
  logic         o_busy;
  logic         o_done;
  logic         o_timeout;
  logic         o_crc_err;
  logic [5:0]   o_resp_idx;
  logic [127:0] o_resp;

  modport master (
    output i_en, i_cmd, i_arg, i_resp_type,
    input  o_busy, o_done, o_timeout, o_crc_err, o_resp_idx, o_resp
  );

  modport slave (
    input  i_en, i_cmd, i_arg, i_resp_type,
    output o_busy, o_done, o_timeout, o_crc_err, o_resp_idx, o_resp
  );
endinterface

// File: rtl/sd_cmd_engine.sv
// rtl/sd_cmd_engine.sv - SD CMD-line engine: SD clock, CRC7 command frame, response capture
// Receive CRC7 check is built only when SD_CMD_RESP_CRC_CHECK_EN is defined.
module sd_cmd_engine #(
  parameter int CLK_DIV      = 2,
  parameter int RESP_TIMEOUT = 64,
  parameter int NCC_GAP      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           sd_clk_o,
  input  logic           sd_cmd_i,
  output logic           sd_cmd_o,
  output logic           sd_cmd_oen,
  sd_cmd_engine_if.slave bus
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIG_PAR = (RESP_TIMEOUT > NCC_GAP) ? RESP_TIMEOUT : NCC_GAP;
  localparam int CNT_MAX = (BIG_PAR > 136) ? BIG_PAR : 136;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_WAIT,
    S_RX,
    S_GAP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sd_clk;
  logic             w_tc;
  logic             w_fall;
  logic             w_rise;

  logic [1:0]       r_type;
  logic [39:0]      r_tx_sh;
  logic [6:0]       r_tx_crc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cmd_o;
  logic             r_cmd_oen;
  logic [126:0]     r_rx_sh;
  logic [127:0]     w_rx_nxt;
  logic [5:0]       r_rx_idx;
  logic [127:0]     r_resp;
  logic [5:0]       r_resp_idx;
  logic             r_timeout;
  logic             w_crc_err;

  logic             w_long;
  logic [CNT_W-1:0] w_rx_last;
  logic             w_accept;
  logic             w_tx_end;
  logic             w_start;
  logic             w_to;
  logic             w_rx_end;
  logic             w_gap_end;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // The strobe is asserted in the cycle whose closing edge toggles sd_clk_o.
  assign w_tc   = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_fall = w_tc & r_sd_clk;
  assign w_rise = w_tc & ~r_sd_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_sd_clk  <= 1'b0;
    end else if (w_tc) begin
      r_div_cnt <= '0;
      r_sd_clk  <= ~r_sd_clk;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  assign w_long    = (r_type == 2'd2);
  assign w_rx_last = w_long ? CNT_W'(135) : CNT_W'(47);
  assign w_accept  = (r_state == S_IDLE) & bus.i_en;
  assign w_tx_end  = w_fall & (r_cnt == CNT_W'(48));
  assign w_start   = w_rise & ~sd_cmd_i;
  assign w_to      = w_rise & sd_cmd_i & (r_cnt == CNT_W'(RESP_TIMEOUT - 1));
  assign w_rx_end  = w_rise & (r_cnt == w_rx_last);
  assign w_gap_end = w_rise & (r_cnt == CNT_W'(NCC_GAP - 1));
  assign w_rx_nxt  = {r_rx_sh, sd_cmd_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A start bit on the final timeout rise wins over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.i_en) w_state_nxt = S_TX;
      S_TX:   if (w_tx_end) w_state_nxt = (r_type == 2'd0) ? S_GAP : S_WAIT;
      S_WAIT: begin
        if (w_start)   w_state_nxt = S_RX;
        else if (w_to) w_state_nxt = S_GAP;
      end
      S_RX:   if (w_rx_end) w_state_nxt = S_GAP;
      S_GAP:  if (w_gap_end) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type     <= 2'd0;
      r_tx_sh    <= '0;
      r_tx_crc   <= '0;
      r_cnt      <= '0;
      r_cmd_o    <= 1'b1;
      r_cmd_oen  <= 1'b1;
      r_rx_sh    <= '0;
      r_rx_idx   <= '0;
      r_resp     <= '0;
      r_resp_idx <= '0;
      r_timeout  <= 1'b0;
    end else begin
      // r_cnt is reused per state: TX falls, WAIT/GAP rises, RX bit position.
      if (r_state != w_state_nxt) begin
        r_cnt <= (w_state_nxt == S_RX) ? CNT_W'(1) : '0;
      end else if (((r_state == S_TX) && w_fall) ||
                   (((r_state == S_WAIT) || (r_state == S_RX) || (r_state == S_GAP)) && w_rise)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_accept) begin
        r_type    <= bus.i_resp_type;
        r_tx_sh   <= {2'b01, bus.i_cmd, bus.i_arg};
        r_tx_crc  <= '0;
        r_timeout <= 1'b0;
      end

      if ((r_state == S_TX) && w_fall) begin
        if (r_cnt < CNT_W'(40)) begin
          r_cmd_oen <= 1'b0;
          r_cmd_o   <= r_tx_sh[39];
          r_tx_sh   <= {r_tx_sh[38:0], 1'b0};
          r_tx_crc  <= crc7_step(r_tx_crc, r_tx_sh[39]);
        end else if (r_cnt < CNT_W'(47)) begin
          r_cmd_o  <= r_tx_crc[6];
          r_tx_crc <= {r_tx_crc[5:0], 1'b0};
        end else if (r_cnt == CNT_W'(47)) begin
          r_cmd_o <= 1'b1;
        end else begin
          r_cmd_oen <= 1'b1;
          r_cmd_o   <= 1'b1;
        end
      end

      if ((r_state == S_WAIT) && w_to && sd_cmd_i) begin
        r_timeout <= 1'b1;
      end

      if ((r_state == S_RX) && w_rise) begin
        r_rx_sh <= w_rx_nxt[126:0];
        if ((r_cnt >= CNT_W'(2)) && (r_cnt <= CNT_W'(7))) begin
          r_rx_idx <= {r_rx_idx[4:0], sd_cmd_i};
        end
        if (w_rx_end) begin
          r_resp_idx <= r_rx_idx;
          r_resp     <= w_long ? w_rx_nxt : {96'd0, w_rx_nxt[39:8]};
        end
      end
    end
  end

`ifdef SD_CMD_RESP_CRC_CHECK_EN
  logic [6:0] r_rx_crc;
  logic       r_crc_err;
  logic       w_rx_crc_en;

  // Start bit is zero and cannot change a zero-seeded CRC, so RX alone feeds it.
  assign w_rx_crc_en = w_long ? ((r_cnt >= CNT_W'(8)) && (r_cnt <= CNT_W'(127)))
                              : (r_cnt <= CNT_W'(39));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_crc  <= '0;
      r_crc_err <= 1'b0;
    end else if (w_accept) begin
      r_rx_crc  <= '0;
      r_crc_err <= 1'b0;
    end else if ((r_state == S_RX) && w_rise) begin
      if (w_rx_crc_en) begin
        r_rx_crc <= crc7_step(r_rx_crc, sd_cmd_i);
      end
      if (w_rx_end) begin
        r_crc_err <= (r_type != 2'd3) && (w_rx_nxt[7:1] != r_rx_crc);
      end
    end
  end

  assign w_crc_err = r_crc_err;
`else
  assign w_crc_err = 1'b0;
`endif

  assign sd_clk_o       = r_sd_clk;
  assign sd_cmd_o       = r_cmd_o;
  assign sd_cmd_oen     = r_cmd_oen;
  assign bus.o_busy     = (r_state != S_IDLE);
  assign bus.o_done     = (r_state == S_DONE);
  assign bus.o_timeout  = r_timeout;
  assign bus.o_crc_err  = w_crc_err;
  assign bus.o_resp_idx = r_resp_idx;
  assign bus.o_resp     = r_resp;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb/tb_sd_cmd_engine.sv - self-checking bench for sd_cmd_engine with a card model and CRC7 reference
module tb_sd_cmd_engine;
  localparam int CLK_DIV      = 2;
  localparam int RESP_TIMEOUT = 64;
  localparam int NCC_GAP      = 8;
  localparam int CYC_PER_SD   = 2 * CLK_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sd_clk_o;
  logic sd_cmd_i;
  logic sd_cmd_o;
  logic sd_cmd_oen;

  int n_cmp    = 0;
  int n_fail   = 0;
  int rise_cnt = 0;
  int done_cnt = 0;
  logic tx_q[$];
  logic [127:0] exp_resp = '0;
  logic [5:0]   exp_idx  = '0;

  sd_cmd_engine_if bus ();

  sd_cmd_engine #(
    .CLK_DIV(CLK_DIV),
    .RESP_TIMEOUT(RESP_TIMEOUT),
    .NCC_GAP(NCC_GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sd_clk_o(sd_clk_o),
    .sd_cmd_i(sd_cmd_i),
    .sd_cmd_o(sd_cmd_o),
    .sd_cmd_oen(sd_cmd_oen),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Card-side view: the card latches the CMD line on the SD clock rising edge.
  always @(posedge sd_clk_o) begin
    rise_cnt++;
    if (sd_cmd_oen === 1'b0) tx_q.push_back(sd_cmd_o);
  end

  always @(posedge clk) if (bus.o_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC7 (x^7+x^3+1, zero seed) over the top n bits of v, MSB first.
  function automatic logic [6:0] crc7(input logic [135:0] v, input int n);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = v[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] cmd, input logic [31:0] arg);
    logic [39:0] d;
    d = {2'b01, cmd, arg};
    return {d, crc7({96'd0, d}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] short_frame(input logic [5:0] idx, input logic [31:0] arg, input bit bad);
    logic [39:0] d;
    logic [6:0]  c;
    d = {2'b00, idx, arg};
    c = crc7({96'd0, d}, 40) ^ {6'd0, bad};
    return {88'd0, d, c, 1'b1};
  endfunction

  function automatic logic [135:0] long_frame(input logic [119:0] cid, input bit bad);
    logic [6:0] c;
    c = crc7({16'd0, cid}, 120) ^ {6'd0, bad};
    return {2'b00, 6'h3F, cid, c, 1'b1};
  endfunction

  task automatic do_cmd(input logic [5:0] cmd, input logic [31:0] arg, input logic [1:0] rt,
                        input bit reply, input int ncr, input logic [135:0] rf, input int rlen,
                        input logic [47:0] exp_tx);
    logic [47:0] got;
    logic        exp_to;
    logic        exp_crc;
    int          budget;
    int          snap;
    int          d0;
    int          exp_rises;

    exp_to  = 1'b0;
    exp_crc = 1'b0;
    if (rt != 2'd0 && !reply) begin
      exp_to = 1'b1;
    end else if (rt == 2'd2 && reply) begin
      exp_idx  = rf[133:128];
      exp_resp = rf[127:0];
      exp_crc  = (crc7({16'd0, rf[127:8]}, 120) != rf[7:1]);
    end else if (rt != 2'd0 && reply) begin
      exp_idx  = rf[45:40];
      exp_resp = {96'd0, rf[39:8]};
      exp_crc  = (rt == 2'd1) && (crc7({96'd0, rf[47:8]}, 40) != rf[7:1]);
    end
`ifndef SD_CMD_RESP_CRC_CHECK_EN
    exp_crc = 1'b0;
`endif
    exp_rises = (rt == 2'd0) ? NCC_GAP : (!reply ? RESP_TIMEOUT + NCC_GAP : ncr + rlen + NCC_GAP);

    tx_q.delete();
    @(negedge clk);
    bus.i_cmd = cmd; bus.i_arg = arg; bus.i_resp_type = rt; bus.i_en = 1'b1;
    @(negedge clk);
    bus.i_en = 1'b0;
    chk("busy_after_accept", bus.o_busy, 1'b1);
    d0 = done_cnt;

    budget = 0;
    while (!(sd_cmd_oen === 1'b1 && tx_q.size() >= 48) && budget < 60 * CYC_PER_SD) begin
      @(negedge clk);
      budget++;
    end
    chk("tx_release_seen", budget < 60 * CYC_PER_SD, 1'b1);
    got = '0;
    for (int i = 0; i < 48; i++) got = {got[46:0], (i < tx_q.size()) ? tx_q[i] : 1'bx};
    chk("tx_frame", got, exp_tx);
    snap = rise_cnt;

    if (reply) begin
      repeat (ncr) @(negedge sd_clk_o);
      for (int i = rlen - 1; i >= 0; i--) begin
        sd_cmd_i = rf[i];
        @(negedge sd_clk_o);
      end
      sd_cmd_i = 1'b1;
    end

    budget = 0;
    while (bus.o_done !== 1'b1 && budget < (RESP_TIMEOUT + NCC_GAP + 150) * CYC_PER_SD) begin
      @(negedge clk);
      budget++;
    end
    chk("done_seen", bus.o_done, 1'b1);
    chk("rises_to_done", rise_cnt - snap, exp_rises);
    chk("timeout_flag", bus.o_timeout, exp_to);
    chk("crc_err_flag", bus.o_crc_err, exp_crc);
    chk("resp_idx", bus.o_resp_idx, exp_idx);
    chk("resp", bus.o_resp, exp_resp);
    @(negedge clk);
    chk("done_single_pulse", done_cnt - d0, 1);
    chk("idle_after_done", {bus.o_busy, bus.o_done}, 2'b00);
  endtask

  initial begin
    logic [127:0] r128;
    logic [1:0]   rt;
    logic [5:0]   cmd;
    logic [31:0]  arg;
    bit           rep;
    bit           bad;
    int           budget;

    sd_cmd_i = 1'b1;
    bus.i_en = 1'b0; bus.i_cmd = '0; bus.i_arg = '0; bus.i_resp_type = '0;
    repeat (3) @(negedge clk);
    chk("rst_sd_clk", sd_clk_o, 1'b0);
    chk("rst_cmd_o", sd_cmd_o, 1'b1);
    chk("rst_cmd_oen", sd_cmd_oen, 1'b1);
    chk("rst_flags", {bus.o_busy, bus.o_done, bus.o_timeout, bus.o_crc_err}, 4'b0000);
    chk("rst_resp", {bus.o_resp_idx, bus.o_resp}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_cmd(6'd0, 32'd0, 2'd0, 1'b0, 0, '0, 48, 48'h40_0000_0000_95);
    do_cmd(6'd8, 32'h1AA, 2'd1, 1'b1, 5, {88'd0, 48'h08_0000_01AA_13}, 48, 48'h48_0000_01AA_87);
    do_cmd(6'd8, 32'h1AA, 2'd1, 1'b1, 5, {88'd0, 48'h08_0000_01AA_15}, 48, 48'h48_0000_01AA_87);
    do_cmd(6'd17, 32'd0, 2'd1, 1'b0, 0, '0, 48, 48'h51_0000_0000_55);
    do_cmd(6'd13, 32'h0001_0000, 2'd1, 1'b1, RESP_TIMEOUT - 1,
           short_frame(6'd13, 32'h0000_0900, 1'b0), 48, cmd_frame(6'd13, 32'h0001_0000));
    r128 = {$urandom, $urandom, $urandom, $urandom};
    do_cmd(6'd2, 32'd0, 2'd2, 1'b1, 3, long_frame(r128[119:0], 1'b0), 136, cmd_frame(6'd2, 32'd0));
    do_cmd(6'd41, 32'h40FF_8000, 2'd3, 1'b1, 2, {88'd0, 2'b00, 6'h3F, 32'hC0FF_8000, 8'hFF}, 48,
           cmd_frame(6'd41, 32'h40FF_8000));

    for (int k = 0; k < 8; k++) begin
      rt  = 2'($urandom_range(0, 3));
      cmd = 6'($urandom);
      arg = $urandom;
      rep = (rt != 2'd0) && ($urandom_range(0, 4) != 0);
      bad = ($urandom_range(0, 1) == 1);
      r128 = {$urandom, $urandom, $urandom, $urandom};
      if (rt == 2'd2)
        do_cmd(cmd, arg, rt, rep, $urandom_range(1, 20), long_frame(r128[119:0], bad), 136, cmd_frame(cmd, arg));
      else
        do_cmd(cmd, arg, rt, rep, $urandom_range(1, 20), short_frame(cmd, r128[31:0], bad), 48, cmd_frame(cmd, arg));
    end

    tx_q.delete();
    @(negedge clk);
    bus.i_cmd = 6'd17; bus.i_arg = $urandom; bus.i_resp_type = 2'd1; bus.i_en = 1'b1;
    @(negedge clk);
    bus.i_en = 1'b0;
    budget = 0;
    while (tx_q.size() < 20 && budget < 40 * CYC_PER_SD) begin
      @(negedge clk);
      budget++;
    end
    chk("reached_bit20", tx_q.size() >= 20, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_sd_clk", sd_clk_o, 1'b0);
    chk("abort_cmd_line", {sd_cmd_o, sd_cmd_oen}, 2'b11);
    chk("abort_flags", {bus.o_busy, bus.o_done, bus.o_timeout, bus.o_crc_err}, 4'b0000);
    chk("abort_resp", {bus.o_resp_idx, bus.o_resp}, '0);
    exp_resp = '0;
    exp_idx  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_cmd(6'd55, 32'd0, 2'd0, 1'b0, 0, '0, 48, 48'h77_0000_0000_65);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
